// File: rtl/alu_seq_driver_if.sv
// alu_seq_driver_if: ALU/memory bus plus result stream between the sequence driver and its consumer.
interface alu_seq_driver_if;
    logic        write_enable;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [3:0]  aluop;
    logic [31:0] data_in2;
    logic [31:0] dataout;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_idx;

    modport master (
        output write_enable, addr, data_in, aluop, data_in2, res_valid, res_data, res_idx,
        input  dataout, res_ready
    );

    modport slave (
        input  write_enable, addr, data_in, aluop, data_in2, res_valid, res_data, res_idx,
        output dataout, res_ready
    );
endinterface

// File: rtl/alu_seq_driver.sv
// alu_seq_driver: runs a fixed 10-step ALU test sequence and streams {step, result} through a FIFO.
// Define ALU_SEQ_PRELOAD_EN to add a 10-cycle memory preload phase before the first step.
module alu_seq_driver #(
    parameter int SETTLE     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    alu_seq_driver_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_SLL = 4'b0001, OP_SLT = 4'b0010,
                           OP_SLTU = 4'b0011, OP_XOR = 4'b0100, OP_SRL = 4'b0101, OP_SRA = 4'b1101,
                           OP_OR = 4'b0110, OP_AND = 4'b0111;
    localparam logic [3:0] OPS [16] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
                                        OP_SRA, OP_OR, OP_AND, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    localparam logic [31:0] D2 [16] = '{32'h01234567, 32'h01234567, 32'h00000010, 32'h0, 32'h0,
                                        32'hF0F0E0E0, 32'h00000010, 32'h00000010, 32'hFFFF0000,
                                        32'hFFFF0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef ALU_SEQ_PRELOAD_EN
        S_PRELOAD,
`endif
        S_ISSUE,
        S_SETTLE,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, nxt;
    logic [3:0] step, wait_cnt;
    logic [35:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic empty, full, push, pop, drive, pre_active;
    logic [35:0] head;

`ifdef ALU_SEQ_PRELOAD_EN
    assign pre_active = state == S_PRELOAD;
`else
    assign pre_active = 1'b0;
`endif

    assign empty = count == '0;
    assign full  = count == (AW+1)'(FIFO_DEPTH);
    assign pop   = !empty && bus.res_ready;
    // A full FIFO still accepts the capture when the head leaves in the same cycle.
    assign push  = state == S_CAPTURE && (!full || pop);
    assign drive = state == S_ISSUE || state == S_SETTLE || state == S_CAPTURE;
    assign head  = fifo_mem[rd_ptr];

    always_comb begin
        nxt = state;
        case (state)
`ifdef ALU_SEQ_PRELOAD_EN
            S_IDLE:    nxt = start ? S_PRELOAD : S_IDLE;
            S_PRELOAD: nxt = step == 4'd9 ? S_ISSUE : S_PRELOAD;
`else
            S_IDLE:    nxt = start ? S_ISSUE : S_IDLE;
`endif
            S_ISSUE:   nxt = S_SETTLE;
            S_SETTLE:  nxt = wait_cnt == 4'(SETTLE - 1) ? S_CAPTURE : S_SETTLE;
            S_CAPTURE: nxt = !push ? S_CAPTURE : step == 4'd9 ? S_DRAIN : S_ISSUE;
            S_DRAIN:   nxt = empty ? S_DONE : S_DRAIN;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            step     <= 4'd0;
            wait_cnt <= 4'd0;
        end else begin
            state    <= nxt;
            step     <= (state == S_IDLE || (pre_active && step == 4'd9)) ? 4'd0 :
                        (pre_active || push) ? step + 4'd1 : step;
            wait_cnt <= state == S_SETTLE ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {step, bus.dataout};
    end

    assign busy             = state != S_IDLE && state != S_DONE;
    assign done             = state == S_DONE;
    assign bus.write_enable = pre_active;
    assign bus.data_in      = pre_active ? {4{8'h10 + {4'h0, step}}} : 32'h0;
    assign bus.addr         = (drive || pre_active) ? {26'd0, step, 2'b00} : 32'h0;
    assign bus.aluop        = drive ? OPS[step] : 4'h0;
    assign bus.data_in2     = drive ? D2[step] : 32'h0;
    assign bus.res_valid    = !empty;
    assign bus.res_data     = empty ? 32'h0 : head[31:0];
    assign bus.res_idx      = empty ? 4'h0 : head[35:32];
endmodule

// File: tb/tb_alu_seq_driver.sv
// tb_alu_seq_driver: drives alu_seq_driver against a behavioural ALU/memory and checks its result stream.
module tb_alu_seq_driver;
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_SLL = 4'b0001, OP_SLT = 4'b0010,
                           OP_SLTU = 4'b0011, OP_XOR = 4'b0100, OP_SRL = 4'b0101, OP_SRA = 4'b1101,
                           OP_OR = 4'b0110, OP_AND = 4'b0111;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, busy, done;
    int checks = 0, errors = 0, done_cnt = 0;
    logic [35:0] got [$];
    logic [31:0] mem [16];
    logic [31:0] exp_tab [10];
    logic [3:0]  ops [10] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
    logic [31:0] d2 [10] = '{32'h01234567, 32'h01234567, 32'h10, 32'h0, 32'h0, 32'hF0F0E0E0,
                             32'h10, 32'h10, 32'hFFFF0000, 32'hFFFF0000};

    alu_seq_driver_if bus ();
    alu_seq_driver #(.SETTLE(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $signed(a) >>> b[4:0];
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 32'h0;
        endcase
    endfunction

    assign bus.dataout = alu_f(bus.aluop, mem[bus.addr[5:2]], bus.data_in2);

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.write_enable) mem[bus.addr[5:2]] <= bus.data_in;
        if (rst_n && bus.res_valid && bus.res_ready) got.push_back({bus.res_idx, bus.res_data});
        if (done) begin
            done_cnt++;
            check("done_busy_low", 36'(busy), 36'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input bit rnd);
        int n = 0;
        while (!done && n < 3000) begin
            if (rnd) bus.res_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check({tag, "_done"}, 36'(done), 36'd1);
        bus.res_ready = 1'b1;
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a);
        int n = 0;
        while (!(busy && !bus.write_enable && bus.addr == a) && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_reach"}, bus.addr, a);
    endtask

    task automatic compare_run(input string tag);
        check({tag, "_count"}, 36'(got.size()), 36'd10);
        for (int i = 0; i < 10; i++)
            if (i < got.size()) check({tag, "_result"}, got[i], {4'(i), exp_tab[i]});
        got.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 36'(busy), 36'd0);
        check({tag, "_done"}, 36'(done), 36'd0);
        check({tag, "_we"}, 36'(bus.write_enable), 36'd0);
        check({tag, "_addr"}, 36'(bus.addr), 36'd0);
        check({tag, "_din"}, 36'(bus.data_in), 36'd0);
        check({tag, "_aluop"}, 36'(bus.aluop), 36'd0);
        check({tag, "_din2"}, 36'(bus.data_in2), 36'd0);
        check({tag, "_rvalid"}, 36'(bus.res_valid), 36'd0);
        check({tag, "_rdata"}, 36'(bus.res_data), 36'd0);
        check({tag, "_ridx"}, 36'(bus.res_idx), 36'd0);
    endtask

    initial begin
        bit act;
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
`ifdef ALU_SEQ_PRELOAD_EN
        for (int k = 0; k < 10; k++) exp_tab[k] = alu_f(ops[k], {4{8'(8'h10 + k)}}, d2[k]);
`else
        exp_tab = '{32'h01234567, 32'hFEDCBA99, 32'h0, 32'h0, 32'h0, 32'hF0F0E0E0, 32'h0, 32'h0,
                    32'hFFFF0000, 32'h0};
`endif
        bus.res_ready = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // First step timing, then the rest of that run with the consumer always ready.
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef ALU_SEQ_PRELOAD_EN
        for (int k = 0; k < 10; k++) begin
            check("pre_we", 36'(bus.write_enable), 36'd1);
            check("pre_addr", 36'(bus.addr), 36'(4 * k));
            check("pre_din", 36'(bus.data_in), 36'({4{8'(8'h10 + k)}}));
            tick();
        end
`endif
        check("issue_busy", 36'(busy), 36'd1);
        check("issue_we", 36'(bus.write_enable), 36'd0);
        check("issue_addr", 36'(bus.addr), 36'd0);
        check("issue_aluop", 36'(bus.aluop), 36'(OP_ADD));
        check("issue_din2", 36'(bus.data_in2), 36'h01234567);
        tick();
        tick();
        check("settle_addr", 36'(bus.addr), 36'd0);
        check("settle_rvalid", 36'(bus.res_valid), 36'd0);
        tick();
        check("capture_rvalid", 36'(bus.res_valid), 36'd0);
        check("capture_din2", 36'(bus.data_in2), 36'h01234567);
        tick();
        check("first_rvalid", 36'(bus.res_valid), 36'd1);
        check("first_ridx", 36'(bus.res_idx), 36'd0);
        check("first_rdata", 36'(bus.res_data), 36'(exp_tab[0]));
        done_cnt = 0;
        wait_done("run1", 1'b0);
        tick();
        check("run1_done_pulses", 36'(done_cnt), 36'd1);
        check("run1_idle", 36'(busy), 36'd0);
        compare_run("run1");

        // Backpressure: FIFO fills, sequencer stalls on step 4.
        bus.res_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        check("bp_addr", 36'(bus.addr), 36'd16);
        check("bp_rvalid", 36'(bus.res_valid), 36'd1);
        check("bp_ridx", 36'(bus.res_idx), 36'd0);
        repeat (10) tick();
        check("bp_still_addr", 36'(bus.addr), 36'd16);
        check("bp_busy", 36'(busy), 36'd1);
        check("bp_nothing_popped", 36'(got.size()), 36'd0);
        done_cnt = 0;
        bus.res_ready = 1'b1;
        wait_done("bp", 1'b0);
        tick();
        check("bp_done_pulses", 36'(done_cnt), 36'd1);
        compare_run("bp");

        // A start pulse during step 3 must not disturb the run.
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_addr("s3", 32'd12);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("s3", 1'b1);
        tick();
        check("s3_done_pulses", 36'(done_cnt), 36'd1);
        check("s3_no_restart", 36'(busy), 36'd0);
        compare_run("s3");

        // start held high: a second run follows DONE without a new edge.
        start = 1'b1;
        tick();
        wait_done("held1", 1'b1);
        compare_run("held1");
        n = 0;
        while (!busy && n < 3) begin
            tick();
            n++;
        end
        check("held_restart", 36'(busy), 36'd1);
        start = 1'b0;
        wait_done("held2", 1'b1);
        tick();
        compare_run("held2");

        // Reset in the middle of step 5 clears everything without a clock edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_addr("r5", 32'd20);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        repeat (2) tick();
        rst_n = 1'b1;
        got.delete();
        act = 1'b0;
        repeat (30) begin
            tick();
            if (busy || bus.res_valid || bus.write_enable || done) act = 1'b1;
        end
        check("post_reset_quiet", 36'(act), 36'd0);

        // Fresh run with a randomly stalling consumer.
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("rand", 1'b1);
        tick();
        check("rand_done_pulses", 36'(done_cnt), 36'd1);
        compare_run("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
